// File: rtl/mac_unit_wave_seq.sv
// Self-sequencing bit-serial MAC: accepts a tile of activations and sign-magnitude weights,
// walks the weight magnitude columns MSB first and returns the accumulated dot product.
// Optional build macro ZERO_COLUMN_SKIP_EN visits only the magnitude columns that have a set bit in some lane.
module mac_unit_wave_seq #(
    parameter int DATA_WIDTH   = 8,
    parameter int VEC_LENGTH   = 8,
    parameter int W_BITS       = 8,
    parameter int ACC_WIDTH    = DATA_WIDTH + 16,
    parameter int RESULT_WIDTH = 2 * DATA_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  act,
    input  logic [VEC_LENGTH-1:0]                  w_sign,
    input  logic [VEC_LENGTH-1:0][W_BITS-2:0]      w_mag,
    input  logic                                   load_accum,
    input  logic [ACC_WIDTH-1:0]                   accum_prev,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [ACC_WIDTH-1:0]                   acc_out,
    output logic [RESULT_WIDTH-1:0]                result
);

    localparam int M          = W_BITS - 1;
    localparam int COL_W      = (M > 1) ? $clog2(M) : 1;
    localparam int TERM_W     = DATA_WIDTH + 1;
    localparam int PSUM_W     = TERM_W + $clog2(VEC_LENGTH);
    localparam int PSUM_REG_W = PSUM_W + M - 1;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_next;
    logic   accept;

    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act_r;
    logic [VEC_LENGTH-1:0]                 w_sign_r;
    logic [VEC_LENGTH-1:0][W_BITS-2:0]     w_mag_r;

    logic [COL_W-1:0] col, col_next, start_col;
    logic             last_col, start_empty;

    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  acc_inc;
    logic signed [PSUM_W-1:0]     psum;
    logic signed [PSUM_W-1:0]     tree [VEC_LENGTH];
    logic signed [PSUM_REG_W-1:0] psum_reg, psum_shift;

`ifdef ZERO_COLUMN_SKIP_EN
    logic [M-1:0] in_mask, start_rem, rem_mask, rem_next;

    function automatic logic [COL_W-1:0] msb_index(input logic [M-1:0] m);
        logic [COL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < M; i++) begin
            if (m[i]) idx = COL_W'(i);
        end
        return idx;
    endfunction

    // Column sequencing follows the set bits of the OR-reduced magnitude mask, highest first.
    always_comb begin
        in_mask = '0;
        for (int j = 0; j < VEC_LENGTH; j++) begin
            in_mask = in_mask | w_mag[j];
        end
        start_col   = msb_index(in_mask);
        start_rem   = in_mask & ~(M'(1) << start_col);
        start_empty = (in_mask == '0);
        col_next    = msb_index(rem_mask);
        rem_next    = rem_mask & ~(M'(1) << col_next);
        last_col    = (rem_mask == '0);
    end
`else
    always_comb begin
        start_col   = COL_W'(M - 1);
        start_empty = 1'b0;
        col_next    = col - COL_W'(1);
        last_col    = (col == '0);
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block is assigned a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = start_empty ? DRAIN : COMPUTE;
            end
            COMPUTE: begin
                if (last_col) state_next = DRAIN;
            end
            DRAIN: begin
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) state_next = start_empty ? DRAIN : COMPUTE;
                    else          state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;

    // Lane terms are one bit wider than the activation so negating the most negative value is exact.
    always_comb begin
        logic signed [TERM_W-1:0] act_ext;
        for (int j = 0; j < VEC_LENGTH; j++) begin
            act_ext = TERM_W'($signed(act_r[j]));
            if (w_mag_r[j][col]) begin
                if (w_sign_r[j]) tree[j] = PSUM_W'(-act_ext);
                else             tree[j] = PSUM_W'(act_ext);
            end else begin
                tree[j] = '0;
            end
        end
        for (int step = 1; step < VEC_LENGTH; step = step * 2) begin
            for (int k = 0; k < VEC_LENGTH; k = k + 2 * step) begin
                tree[k] = tree[k] + tree[k + step];
            end
        end
        psum       = tree[0];
        psum_shift = PSUM_REG_W'(psum) <<< col;
        acc_inc    = ACC_WIDTH'(psum_reg);
    end

    // NOTE: operand registers carry no reset; they are loaded on every accept before anything reads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            act_r    <= act;
            w_sign_r <= w_sign;
            w_mag_r  <= w_mag;
        end
    end

    // psum_reg lags the column walk by one edge, so DRAIN folds in the final column.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            psum_reg <= '0;
            col      <= '0;
`ifdef ZERO_COLUMN_SKIP_EN
            rem_mask <= '0;
`endif
        end else if (accept) begin
            acc      <= load_accum ? accum_prev : acc;
            psum_reg <= '0;
            col      <= start_col;
`ifdef ZERO_COLUMN_SKIP_EN
            rem_mask <= start_rem;
`endif
        end else if (state == COMPUTE) begin
            psum_reg <= psum_shift;
            acc      <= acc + acc_inc;
            col      <= col_next;
`ifdef ZERO_COLUMN_SKIP_EN
            rem_mask <= rem_next;
`endif
        end else if (state == DRAIN) begin
            acc <= acc + acc_inc;
        end
    end

    assign acc_out = acc;
    assign result  = acc[ACC_WIDTH-1 -: RESULT_WIDTH];

endmodule

// File: doc/mac_unit_wave_seq.md
Name: mac_unit_wave_seq

Overview:
Parametrised, self-sequencing successor to the 8-lane bit-serial MAC.
- Accepts one tile per handshake: VEC_LENGTH activations plus sign-magnitude weights.
- Walks the weight magnitude bit-columns internally, MSB to LSB, one column per cycle.
- Accumulates the shifted column partial sums and presents the result over a valid/ready output handshake.
- Sits between the activation/weight buffers and the output writeback in the PE array.

Parameters:
DATA_WIDTH, 8, signed activation width
VEC_LENGTH, 8, lanes per tile; power of 2, >=2
W_BITS, 8, weight width in sign-magnitude; magnitude columns M = W_BITS-1
ACC_WIDTH, DATA_WIDTH+16, accumulator width
RESULT_WIDTH, 2*DATA_WIDTH, truncated result width; <= ACC_WIDTH

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  tile valid
in_ready  out  1  tile may be accepted
act  in  VEC_LENGTH x DATA_WIDTH  signed activations
w_sign  in  VEC_LENGTH x 1  per-lane weight sign; 1 = negative
w_mag  in  VEC_LENGTH x (W_BITS-1)  per-lane weight magnitude
load_accum  in  1  sampled at accept: 1 loads accum_prev, 0 continues from current acc
accum_prev  in  ACC_WIDTH  signed seed value
out_valid  out  1  result valid
out_ready  in  1  result consumed
acc_out  out  ACC_WIDTH  full signed accumulator
result  out  RESULT_WIDTH  acc_out[ACC_WIDTH-1 -: RESULT_WIDTH]

Behaviour:
- Reset: IDLE; acc, psum_reg and column counter cleared to 0; out_valid=0, in_ready=1 on the following cycle. Reset mid-operation discards the in-flight tile.
- State machine states: IDLE, COMPUTE, DRAIN, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept = in_valid & in_ready. On accept:
  - act, w_sign and w_mag are registered.
  - acc <= load_accum ? accum_prev : acc.
  - psum_reg <= 0, col <= M-1, state -> COMPUTE.
- COMPUTE, one edge per column c:
  - lane term = w_mag[j][c] ? (w_sign[j] ? -act[j] : act[j]) : 0.
  - The term is DATA_WIDTH+1 bits wide, so -(-2^(DATA_WIDTH-1)) is exact.
  - Adder tree of depth log2(VEC_LENGTH) produces psum of DATA_WIDTH+1+log2(VEC_LENGTH) bits, sign-extended, no overflow.
  - psum_reg <= psum <<< c, at width psum+M-1.
  - acc <= acc + psum_reg, with psum_reg sign-extended.
  - col decrements; after the c=0 edge, state -> DRAIN.
- DRAIN: acc <= acc + psum_reg; state -> DONE.
- DONE: out_valid=1.
  - acc_out and result are held stable while out_ready=0.
  - On out_ready: go to IDLE, or straight to COMPUTE if a new tile is accepted on the same edge.
- Latency: out_valid rises M+1 cycles after the accept edge. Throughput is one tile per M+2 cycles with out_ready=1.
- Accumulator wraps modulo 2^ACC_WIDTH, with no saturation.
- acc_out is visible in all states but only meaningful in DONE.
- in_valid while busy is ignored; no internal tile buffering.

Optional Feature:
Macro ZERO_COLUMN_SKIP_EN.
- Defined:
  - At accept, mask[c] = OR over lanes of w_mag[j][c].
  - COMPUTE visits only the set columns, highest first, via a priority encoder on the remaining mask.
  - N = popcount(mask); latency = N+1.
  - N=0: accept goes directly to DRAIN with psum_reg=0, giving latency 1 and acc unchanged.
- Undefined: all M columns are always visited; latency fixed at M+1.
- Arithmetic results are identical in both builds.

Test Plan:
1. Defaults. All act=1, w_sign=0, w_mag=1, load_accum=1, accum_prev=0 -> acc_out=8, result=0, out_valid exactly 8 cycles after accept.
2. All act=-128, w_sign=1, w_mag=127, load_accum=1, accum_prev=0 -> acc_out=130048 (no negation overflow).
3. Test 1 tile, then the same tile with load_accum=0 -> acc_out=16. Then load_accum=1, accum_prev=-5, same tile -> acc_out=3.
4. Hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, acc_out stable, in_ready=0. Raise out_ready with in_valid=1 -> back-to-back accept on the same edge.
5. Assert reset 3 cycles into COMPUTE -> next cycle out_valid=0, acc_out=0, in_ready=1. A following test 1 tile gives 8.
6. Only lane 0 has w_mag=8 (bit 3), act=3 -> acc_out=24. Latency is 2 cycles with ZERO_COLUMN_SKIP_EN, 8 without. All-zero weights give latency 1 (EN) and acc unchanged.
